// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - strobe bundle between control_sequencer and data_path
interface control_sequencer_if;
    logic [31:0] IR;
    logic        CON;

    logic        PCout;
    logic        MDRout;
    logic        Zhighout;
    logic        Zlowout;
    logic        HIout;
    logic        LOout;
    logic        InPortout;
    logic        Cout;

    logic        PCin;
    logic        IncPC;
    logic        MARin;
    logic        MDRin;
    logic        IRin;
    logic        Yin;
    logic        Zhighin;
    logic        Zlowin;
    logic        HIin;
    logic        LOin;
    logic        OutPortin;
    logic        CONin;

    logic        Gra;
    logic        Grb;
    logic        Grc;
    logic        Rin;
    logic        Rout;
    logic        BAout;

    logic        Read;
    logic        Write;

    logic [4:0]  op;
    logic        run;
    logic        illegal;

    modport master (
        input  IR, CON,
        output PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout,
        output PCin, IncPC, MARin, MDRin, IRin, Yin, Zhighin, Zlowin,
        output HIin, LOin, OutPortin, CONin,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output Read, Write, op, run, illegal
    );

    modport slave (
        output IR, CON,
        input  PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout,
        input  PCin, IncPC, MARin, MDRin, IRin, Yin, Zhighin, Zlowin,
        input  HIin, LOin, OutPortin, CONin,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  Read, Write, op, run, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired T-state control unit for the mini CPU datapath
module control_sequencer (
    input  logic                Clock,
    input  logic                clear_n,
    control_sequencer_if.master cs
);
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_RMAX = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RESET,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_ALU,
        C_IMM,
        C_LD,
        C_LDI,
        C_ST,
        C_BR,
        C_NOP,
        C_HALT
    } class_t;

    state_t     state;
    state_t     state_nxt;
    class_t     cls;
    logic       undef_op;
    logic       illegal_q;
    logic [4:0] opcode;
    logic       unused_ir_bits;

    assign opcode         = cs.IR[31:27];
    assign unused_ir_bits = ^cs.IR[26:0];

    // Undefined opcodes fall into the nop class so they only cost a 4-cycle slot.
    always_comb begin
        cls      = C_NOP;
        undef_op = 1'b0;
        case (opcode)
            OP_LD:                   cls = C_LD;
            OP_LDI:                  cls = C_LDI;
            OP_ST:                   cls = C_ST;
            OP_BR:                   cls = C_BR;
            OP_NOP:                  cls = C_NOP;
            OP_HALT:                 cls = C_HALT;
            OP_ADDI, OP_ANDI, OP_ORI: cls = C_IMM;
            default: begin
                if (opcode <= OP_RMAX) begin
                    cls = C_ALU;
                end else begin
                    cls      = C_NOP;
                    undef_op = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge Clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= S_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clock or negedge clear_n) begin
        if (!clear_n) begin
            illegal_q <= 1'b0;
        end else if (state == S_T3 && undef_op) begin
            illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET: state_nxt = S_T0;
            S_T0:    state_nxt = S_T1;
            S_T1:    state_nxt = S_T2;
            S_T2:    state_nxt = S_T3;
            S_T3: begin
                if (cls == C_HALT) begin
                    state_nxt = S_HALT;
                end else if (cls == C_NOP) begin
                    state_nxt = S_T0;
                end else begin
                    state_nxt = S_T4;
                end
            end
            S_T4:    state_nxt = S_T5;
            S_T5: begin
                if (cls == C_ALU || cls == C_IMM || cls == C_LDI) begin
                    state_nxt = S_T0;
                end else begin
                    state_nxt = S_T6;
                end
            end
            S_T6:    state_nxt = (cls == C_LD) ? S_T7 : S_T0;
            S_T7:    state_nxt = S_T0;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_RESET;
        endcase
    end

    assign cs.run     = (state != S_RESET) && (state != S_HALT);
    assign cs.illegal = illegal_q;

    always_comb begin
        cs.PCout     = 1'b0;
        cs.MDRout    = 1'b0;
        cs.Zhighout  = 1'b0;
        cs.Zlowout   = 1'b0;
        cs.HIout     = 1'b0;
        cs.LOout     = 1'b0;
        cs.InPortout = 1'b0;
        cs.Cout      = 1'b0;
        cs.PCin      = 1'b0;
        cs.IncPC     = 1'b0;
        cs.MARin     = 1'b0;
        cs.MDRin     = 1'b0;
        cs.IRin      = 1'b0;
        cs.Yin       = 1'b0;
        cs.Zhighin   = 1'b0;
        cs.Zlowin    = 1'b0;
        cs.HIin      = 1'b0;
        cs.LOin      = 1'b0;
        cs.OutPortin = 1'b0;
        cs.CONin     = 1'b0;
        cs.Gra       = 1'b0;
        cs.Grb       = 1'b0;
        cs.Grc       = 1'b0;
        cs.Rin       = 1'b0;
        cs.Rout      = 1'b0;
        cs.BAout     = 1'b0;
        cs.Read      = 1'b0;
        cs.Write     = 1'b0;
        cs.op        = 5'b00000;
        case (state)
            S_T0: begin
                cs.PCout   = 1'b1;
                cs.MARin   = 1'b1;
                cs.IncPC   = 1'b1;
                cs.Zhighin = 1'b1;
                cs.Zlowin  = 1'b1;
            end
            S_T1: begin
                cs.Zlowout = 1'b1;
                cs.PCin    = 1'b1;
                cs.Read    = 1'b1;
                cs.MDRin   = 1'b1;
            end
            S_T2: begin
                cs.MDRout = 1'b1;
                cs.IRin   = 1'b1;
            end
            S_T3: begin
                case (cls)
                    C_ALU, C_IMM: begin
                        cs.Grb  = 1'b1;
                        cs.Rout = 1'b1;
                        cs.Yin  = 1'b1;
                    end
                    C_LD, C_LDI, C_ST: begin
                        cs.Grb   = 1'b1;
                        cs.BAout = 1'b1;
                        cs.Yin   = 1'b1;
                    end
                    C_BR: begin
                        cs.Gra   = 1'b1;
                        cs.Rout  = 1'b1;
                        cs.CONin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_ALU: begin
                        cs.Grc     = 1'b1;
                        cs.Rout    = 1'b1;
                        cs.Zhighin = 1'b1;
                        cs.Zlowin  = 1'b1;
                        cs.op      = opcode;
                    end
                    C_IMM: begin
                        cs.Cout    = 1'b1;
                        cs.Zhighin = 1'b1;
                        cs.Zlowin  = 1'b1;
                        cs.op      = opcode;
                    end
                    C_LD, C_LDI, C_ST: begin
                        cs.Cout   = 1'b1;
                        cs.Zlowin = 1'b1;
                        cs.op     = OP_ADD;
                    end
                    C_BR: begin
                        cs.PCout = 1'b1;
                        cs.Yin   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_ALU, C_IMM, C_LDI: begin
                        cs.Zlowout = 1'b1;
                        cs.Gra     = 1'b1;
                        cs.Rin     = 1'b1;
                    end
                    C_LD, C_ST: begin
                        cs.Zlowout = 1'b1;
                        cs.MARin   = 1'b1;
                    end
                    C_BR: begin
                        cs.Cout   = 1'b1;
                        cs.Zlowin = 1'b1;
                        cs.op     = OP_ADD;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    C_LD: begin
                        cs.Read  = 1'b1;
                        cs.MDRin = 1'b1;
                    end
                    C_ST: begin
                        cs.Gra   = 1'b1;
                        cs.Rout  = 1'b1;
                        cs.Write = 1'b1;
                    end
                    C_BR: begin
                        // Branch taken only when the condition flag is high during this state.
                        cs.Zlowout = cs.CON;
                        cs.PCin    = cs.CON;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                cs.MDRout = 1'b1;
                cs.Gra    = 1'b1;
                cs.Rin    = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
